// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the 8-channel demux sequencer.
package demux_seq_pkg;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [N_CH-1:0]  chmask_t;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_seq_8_if.sv
// Word-in handshake plus demux strobe bundle; master = upstream/driver, slave = sequencer.
interface demux_seq_8_if;
    import demux_seq_pkg::*;

    logic    in_valid;
    logic    in_ready;
    chmask_t in_data;
    chmask_t in_mask;
    logic    hold;
    sel_t    sel;
    logic    din;
    logic    dout_en;
    logic    busy;
    logic    done;

    modport master (
        output in_valid, in_data, in_mask, hold,
        input  in_ready, sel, din, dout_en, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_mask, hold,
        output in_ready, sel, din, dout_en, busy, done
    );
endinterface

// File: rtl/pri_enc_8.sv
// Purpose: 8-bit priority encoder, lowest-first or highest-first.
// Latency: purely combinational.
// Backpressure: none.
module pri_enc_8
    import demux_seq_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  chmask_t req_i,
    output sel_t    idx_o,
    output logic    any_o
);
    // The last matching iteration wins, so the scan direction picks the priority.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        if (MSB_FIRST) begin
            for (int i = 0; i < N_CH; i++) begin
                if (req_i[i]) idx_o = sel_t'(i);
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = sel_t'(i);
            end
        end
    end
endmodule

// File: rtl/demux_seq_8.sv
// Purpose: accepts a data word + channel mask, strobes each enabled channel into the demux.
// Latency: k strobes on cycles N+1..N+k, done at N+k+1, ready again at N+k+2.
// Backpressure: in_ready low outside IDLE; hold stalls stepping in SHIFT one cycle per cycle held.
module demux_seq_8
    import demux_seq_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic           clk,
    input logic           rst,
    demux_seq_8_if.slave  bus
);
    state_t  state_q, state_d;
    chmask_t data_q, data_d;
    chmask_t rem_q, rem_d;
    sel_t    ptr_q, ptr_d;

    chmask_t rem_left;
    sel_t    first_idx, next_idx;
    logic    first_any, next_any;

    // Remaining channels once the current one has been strobed.
    assign rem_left = rem_q & ~(chmask_t'(1) << ptr_q);

    pri_enc_8 #(.MSB_FIRST(MSB_FIRST)) u_enc_first (
        .req_i (bus.in_mask),
        .idx_o (first_idx),
        .any_o (first_any)
    );

    pri_enc_8 #(.MSB_FIRST(MSB_FIRST)) u_enc_next (
        .req_i (rem_left),
        .idx_o (next_idx),
        .any_o (next_any)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d = bus.in_data;
                    rem_d  = bus.in_mask;
                    if (first_any) begin
                        ptr_d   = first_idx;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (!bus.hold) begin
                    rem_d = rem_left;
                    if (next_any) ptr_d   = next_idx;
                    else          state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE) & ~rst;
    assign bus.sel      = ptr_q;
    assign bus.din      = data_q[ptr_q];
    assign bus.dout_en  = (state_q == ST_SHIFT) & ~bus.hold;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_demux_seq_8.sv
// Self-checking bench: directed vector table, hand sequences for reset/busy, randomized words vs a list model.
module tb_demux_seq_8;
    import demux_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_seq_8_if b0();
    demux_seq_8_if b1();

    demux_seq_8 #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    demux_seq_8 #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rdy;
        logic [2:0] sel;
        logic       din;
        logic       en;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        bit          m;
        logic [7:0]  d;
        logic [7:0]  mk;
        int          h_after;
        int          h_len;
        int          exp_n;
        logic [31:0] exp_sel;   // one nibble per strobe, first strobe in [3:0]
        logic [7:0]  exp_din;   // one bit per strobe, first strobe in [0]
        int          exp_done;
        int          exp_hsel;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit m, input logic v, input logic [7:0] d,
                         input logic [7:0] mk, input logic h);
        if (m) begin
            b1.in_valid = v; b1.in_data = d; b1.in_mask = mk; b1.hold = h;
        end else begin
            b0.in_valid = v; b0.in_data = d; b0.in_mask = mk; b0.hold = h;
        end
    endtask

    function automatic obs_t get(input bit m);
        obs_t o;
        if (m) begin
            o.rdy = b1.in_ready; o.sel = b1.sel; o.din = b1.din;
            o.en = b1.dout_en; o.busy = b1.busy; o.done = b1.done;
        end else begin
            o.rdy = b0.in_ready; o.sel = b0.sel; o.din = b0.din;
            o.en = b0.dout_en; o.busy = b0.busy; o.done = b0.done;
        end
        return o;
    endfunction

    // Issue one word, then record strobes, hold behaviour and done/ready timing.
    task automatic run_vec(input vec_t v, input string tag);
        obs_t        o;
        int          n, held, done_at, ready_at, hsel;
        logic [31:0] sels;
        logic [7:0]  dins;
        logic        prev_done, hold_en, h;
        n = 0; held = 0; done_at = -1; ready_at = -1; hsel = -1;
        sels = '0; dins = '0; prev_done = 1'b0; hold_en = 1'b0;
        @(posedge clk); #1 drive(v.m, 1'b1, v.d, v.mk, 1'b0);
        @(negedge clk); o = get(v.m);
        chk({tag, ".ready_before"}, 32'(o.rdy), 32'd1);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 40 && ready_at < 0; cyc++) begin
            h = (n == v.h_after) && (held < v.h_len);
            drive(v.m, 1'b0, 8'h00, 8'h00, h);
            @(negedge clk); o = get(v.m);
            if (h) begin
                held++;
                hsel = int'(o.sel);
                if (o.en) hold_en = 1'b1;
            end
            if (o.en) begin
                if (n < 8) begin
                    sels[n*4 +: 4] = {1'b0, o.sel};
                    dins[n] = o.din;
                end
                n++;
            end
            chk({tag, ".done_twice"}, 32'(o.done & prev_done), 32'd0);
            if (o.done && done_at < 0) done_at = cyc;
            prev_done = o.done;
            if (o.rdy) ready_at = cyc;
            @(posedge clk); #1;
        end
        drive(v.m, 1'b0, 8'h00, 8'h00, 1'b0);
        chk({tag, ".strobes"},  32'(n),        32'(v.exp_n));
        chk({tag, ".sel_seq"},  sels,          v.exp_sel);
        chk({tag, ".din_seq"},  32'(dins),     32'(v.exp_din));
        chk({tag, ".done_at"},  32'(done_at),  32'(v.exp_done));
        chk({tag, ".ready_at"}, 32'(ready_at), 32'(v.exp_done + 1));
        if (v.h_len > 0) begin
            chk({tag, ".hold_sel"}, 32'(hsel),    32'(v.exp_hsel));
            chk({tag, ".hold_en"},  32'(hold_en), 32'd0);
        end
    endtask

    // Entered at posedge+1; rst held for ncyc cycles.
    task automatic do_reset(input int ncyc, input string tag);
        obs_t o;
        rst = 1'b1;
        @(negedge clk);
        chk({tag, ".ready_in_rst0"}, 32'(get(0).rdy), 32'd0);
        chk({tag, ".ready_in_rst1"}, 32'(get(1).rdy), 32'd0);
        for (int i = 1; i < ncyc; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".outs_in_rst0"}, 32'(get(0)), 32'h00);
            chk({tag, ".outs_in_rst1"}, 32'(get(1)), 32'h00);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk({tag, ".after_rst0"}, 32'(get(0)), 32'h80);
        chk({tag, ".after_rst1"}, 32'(get(1)), 32'h80);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk); o = get(0);
            chk({tag, ".no_done"}, 32'({o.done, o.busy}), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // Randomized words checked cycle by cycle against the list of channels to visit.
    task automatic rand_words(input int nw);
        obs_t       o;
        bit         m, h, dn, fin;
        logic [7:0] d, mk;
        int         lst[$];
        int         pos, ch;
        for (int w = 0; w < nw; w++) begin
            m  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            mk = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mk = 8'h00;
            lst.delete();
            for (int k = 0; k < 8; k++) begin
                ch = m ? 7 - k : k;
                if (mk[ch]) lst.push_back(ch);
            end
            @(posedge clk); #1 drive(m, 1'b1, d, mk, 1'b0);
            @(negedge clk);
            chk("rand.ready_before", 32'(get(m).rdy), 32'd1);
            @(posedge clk); #1;
            pos = 0; dn = 1'b0; fin = 1'b0;
            for (int c = 0; c < 60 && !fin; c++) begin
                h = ($urandom_range(0, 3) == 0);
                drive(m, 1'b0, 8'h00, 8'h00, h);
                @(negedge clk); o = get(m);
                if (pos < lst.size()) begin
                    chk("rand.busy", 32'(o.busy), 32'd1);
                    chk("rand.en",   32'(o.en),   32'(!h));
                    chk("rand.sel",  32'(o.sel),  32'(lst[pos]));
                    chk("rand.din",  32'(o.din),  32'(d[lst[pos]]));
                    chk("rand.done_early", 32'(o.done), 32'd0);
                    if (!h) pos++;
                end else if (!dn) begin
                    chk("rand.done", 32'({o.done, o.en}), 32'b10);
                    dn = 1'b1;
                end else begin
                    chk("rand.idle", 32'({o.rdy, o.busy, o.done}), 32'b100);
                    fin = 1'b1;
                end
                @(posedge clk); #1;
            end
            chk("rand.finished", 32'(fin), 32'd1);
            drive(m, 1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        vec_t v02;
        obs_t o;
        int   ens, dones;

        vecs[0] = '{1'b0, 8'hA5, 8'hFF, -1, 0, 8, 32'h76543210, 8'hA5, 9, -1};
        vecs[1] = '{1'b0, 8'hFF, 8'h81, -1, 0, 2, 32'h00000070, 8'h03, 3, -1};
        vecs[2] = '{1'b0, 8'h3C, 8'h00, -1, 0, 0, 32'h00000000, 8'h00, 1, -1};
        vecs[3] = '{1'b0, 8'hA5, 8'hFF,  2, 3, 8, 32'h76543210, 8'hA5, 12, 2};
        vecs[4] = '{1'b1, 8'h05, 8'h0F, -1, 0, 4, 32'h00000123, 8'h0A, 5, -1};
        vecs[5] = '{1'b1, 8'h81, 8'h81, -1, 0, 2, 32'h00000007, 8'h03, 3, -1};
        v02     = '{1'b0, 8'h02, 8'h02, -1, 0, 1, 32'h00000001, 8'h01, 2, -1};

        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Power-on reset, two cycles.
        @(posedge clk); #1;
        do_reset(2, "por");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset after three strobes of a full-mask word.
        @(posedge clk); #1 drive(1'b0, 1'b1, 8'hA5, 8'hFF, 1'b0);
        @(posedge clk); #1 drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); o = get(0);
            chk("midrst.strobe", 32'({o.en, o.sel}), 32'({1'b1, 3'(s)}));
            @(posedge clk); #1;
        end
        do_reset(1, "midrst");
        run_vec(v02, "after_midrst");

        // in_valid while busy must be ignored.
        @(posedge clk); #1 drive(1'b1, 1'b1, 8'h05, 8'h0F, 1'b0);
        @(posedge clk); #1;
        ens = 0; dones = 0;
        for (int c = 1; c <= 12; c++) begin
            drive(1'b1, c == 2, 8'hFF, 8'hFF, 1'b0);
            @(negedge clk); o = get(1);
            if (c == 2) chk("busy_ign.ready", 32'({o.rdy, o.busy}), 32'b01);
            ens   += int'(o.en);
            dones += int'(o.done);
            @(posedge clk); #1;
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("busy_ign.strobes", 32'(ens), 32'd4);
        chk("busy_ign.dones",   32'(dones), 32'd1);
        chk("busy_ign.idle",    32'(get(1).busy), 32'd0);

        rand_words(40);

        // Mid-stimulus two-cycle reset during a word on the MSB-first instance.
        @(posedge clk); #1 drive(1'b1, 1'b1, 8'hC3, 8'hF0, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        do_reset(2, "rst2");
        run_vec(vecs[4], "after_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
